// File: rtl/rx_cpu_pkg.sv
// Shared types and widths for the network->CPU receive packet buffer.
package rx_cpu_pkg;

    // Packet interface widths (data bus and empty-byte count).
    localparam int unsigned PKT_DW = 64;
    localparam int unsigned PKT_EW = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STORE = 2'd1,
        DROP  = 2'd2
    } rx_cpu_state_t;

    // One buffered beat: framing flags travel with the data.
    typedef struct packed {
        logic              sop;
        logic              eop;
        logic [PKT_EW-1:0] empty;
        logic [PKT_DW-1:0] data;
    } ram_word_t;

    localparam int unsigned RAM_W = $bits(ram_word_t);

endpackage

// File: rtl/rx_cpu_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered output.
module rx_cpu_ram #(
    parameter int unsigned AWIDTH = 9,
    parameter int unsigned DW     = 69
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [DW-1:0]     wr_data,
    input  logic              rd_en,
    input  logic [AWIDTH-1:0] rd_addr,
    output logic [DW-1:0]     rd_data
);

    logic [DW-1:0] mem [0:(1 << AWIDTH)-1];

    // Write port and one-cycle registered read port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/rx_cpu.sv
// Store-and-forward receive buffer: only complete, error-free packets that fit in the RAM
// become visible on the CPU side; overflowed or errored packets are rolled back and counted.
module rx_cpu
    import rx_cpu_pkg::*;
#(
    parameter int unsigned AWIDTH = 9,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    // Network side
    input  logic [PKT_DW-1:0] pkt_i_data,
    input  logic [PKT_EW-1:0] pkt_i_empty,
    input  logic              pkt_i_sop,
    input  logic              pkt_i_eop,
    input  logic              pkt_i_val,
    input  logic              pkt_i_err,
    output logic              pkt_i_ready,
    // CPU side
    output logic [PKT_DW-1:0] pkt_o_data,
    output logic [PKT_EW-1:0] pkt_o_empty,
    output logic              pkt_o_sop,
    output logic              pkt_o_eop,
    output logic              pkt_o_val,
    output logic              pkt_o_err,
    input  logic              pkt_o_ready,
    // Status
    output logic              pkt_avail_o,
    output logic [CNT_W-1:0]  rx_pkt_cnt_o,
    output logic [CNT_W-1:0]  drop_ovf_cnt_o,
    output logic [CNT_W-1:0]  drop_err_cnt_o
);

    localparam logic [AWIDTH:0]  DEPTH   = {1'b1, {AWIDTH{1'b0}}};
    localparam logic [AWIDTH:0]  PTR_ONE = {{AWIDTH{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    rx_cpu_state_t state, state_next;

    // wr_ptr runs ahead speculatively; cmt_ptr marks the end of committed packets.
    logic [AWIDTH:0] wr_ptr, wr_ptr_next;
    logic [AWIDTH:0] cmt_ptr, cmt_ptr_next;
    logic [AWIDTH:0] rd_ptr, rd_ptr_next;

    logic [CNT_W-1:0] rx_cnt, ovf_cnt, err_cnt;
    logic             inc_rx, inc_ovf, inc_err;

    logic              ram_we;
    logic [AWIDTH-1:0] ram_waddr;
    ram_word_t         in_word;
    ram_word_t         ram_rdata;

    logic full_wr, full_cmt, start_pkt;

    // Read pipeline: RAM read in flight, skid register, output register.
    logic      issue, pend, pop;
    logic [1:0] held;
    logic      out_val, out_val_next, skid_val, skid_val_next;
    ram_word_t out_word, out_word_next, skid_word, skid_word_next;
    logic      avail, avail_next;

    assign in_word  = '{sop: pkt_i_sop, eop: pkt_i_eop, empty: pkt_i_empty, data: pkt_i_data};
    assign full_wr  = (wr_ptr - rd_ptr) == DEPTH;
    assign full_cmt = (cmt_ptr - rd_ptr) == DEPTH;

    rx_cpu_ram #(
        .AWIDTH (AWIDTH),
        .DW     (RAM_W)
    ) u_ram (
        .clk     (clk_i),
        .wr_en   (ram_we),
        .wr_addr (ram_waddr),
        .wr_data (in_word),
        .rd_en   (issue),
        .rd_addr (rd_ptr[AWIDTH-1:0]),
        .rd_data (ram_rdata)
    );

    // Write-side FSM: decides what to do with each accepted network word.
    always_comb begin
        state_next   = state;
        wr_ptr_next  = wr_ptr;
        cmt_ptr_next = cmt_ptr;
        ram_we       = 1'b0;
        ram_waddr    = wr_ptr[AWIDTH-1:0];
        inc_rx       = 1'b0;
        inc_ovf      = 1'b0;
        inc_err      = 1'b0;
        start_pkt    = 1'b0;

        unique case (state)
            IDLE: begin
                if (pkt_i_val && pkt_i_sop) begin
                    start_pkt = 1'b1;
                end
            end
            STORE: begin
                if (pkt_i_val) begin
                    if (full_wr) begin
                        // Overflow wins over err and over a premature sop.
                        wr_ptr_next = cmt_ptr;
                        inc_ovf     = 1'b1;
                        state_next  = pkt_i_eop ? IDLE : DROP;
                    end else if (pkt_i_sop) begin
                        // Missing eop: silently discard and restart from this word.
                        start_pkt = 1'b1;
                    end else if (pkt_i_eop && pkt_i_err) begin
                        wr_ptr_next = cmt_ptr;
                        inc_err     = 1'b1;
                        state_next  = IDLE;
                    end else if (pkt_i_eop) begin
                        ram_we       = 1'b1;
                        wr_ptr_next  = wr_ptr + PTR_ONE;
                        cmt_ptr_next = wr_ptr + PTR_ONE;
                        inc_rx       = 1'b1;
                        state_next   = IDLE;
                    end else begin
                        ram_we      = 1'b1;
                        wr_ptr_next = wr_ptr + PTR_ONE;
                    end
                end
            end
            DROP: begin
                if (pkt_i_val && pkt_i_sop) begin
                    start_pkt = 1'b1;
                end else if (pkt_i_val && pkt_i_eop) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A new packet always starts from the committed boundary.
        if (start_pkt) begin
            ram_waddr = cmt_ptr[AWIDTH-1:0];
            if (full_cmt) begin
                wr_ptr_next = cmt_ptr;
                inc_ovf     = 1'b1;
                state_next  = pkt_i_eop ? IDLE : DROP;
            end else if (pkt_i_eop) begin
                state_next = IDLE;
                if (pkt_i_err) begin
                    wr_ptr_next = cmt_ptr;
                    inc_err     = 1'b1;
                end else begin
                    ram_we       = 1'b1;
                    wr_ptr_next  = cmt_ptr + PTR_ONE;
                    cmt_ptr_next = cmt_ptr + PTR_ONE;
                    inc_rx       = 1'b1;
                end
            end else begin
                ram_we      = 1'b1;
                wr_ptr_next = cmt_ptr + PTR_ONE;
                state_next  = STORE;
            end
        end
    end

    // Issue a read only while the skid plus output register can absorb the returning word.
    assign pop         = out_val && pkt_o_ready;
    assign held        = 2'(out_val) + 2'(skid_val) + 2'(pend);
    assign issue       = (rd_ptr != cmt_ptr) && ((held - 2'(pop)) < 2'd2);
    assign rd_ptr_next = issue ? rd_ptr + PTR_ONE : rd_ptr;

    // Output register refill order: skid first, then the word returning from RAM.
    always_comb begin
        out_val_next   = out_val;
        out_word_next  = out_word;
        skid_val_next  = skid_val;
        skid_word_next = skid_word;
        if (!out_val || pkt_o_ready) begin
            if (skid_val) begin
                out_val_next   = 1'b1;
                out_word_next  = skid_word;
                skid_val_next  = pend;
                skid_word_next = ram_rdata;
            end else begin
                out_val_next  = pend;
                out_word_next = ram_rdata;
            end
        end else if (pend) begin
            skid_val_next  = 1'b1;
            skid_word_next = ram_rdata;
        end
    end

    // Anything committed and not yet handed to the CPU keeps pkt_avail_o high.
    assign avail_next = (rd_ptr_next != cmt_ptr_next) || out_val_next || skid_val_next || issue;

    // Control state, pointers and counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            cmt_ptr  <= '0;
            rd_ptr   <= '0;
            pend     <= 1'b0;
            out_val  <= 1'b0;
            skid_val <= 1'b0;
            avail    <= 1'b0;
            rx_cnt   <= '0;
            ovf_cnt  <= '0;
            err_cnt  <= '0;
        end else begin
            state    <= state_next;
            wr_ptr   <= wr_ptr_next;
            cmt_ptr  <= cmt_ptr_next;
            rd_ptr   <= rd_ptr_next;
            pend     <= issue;
            out_val  <= out_val_next;
            skid_val <= skid_val_next;
            avail    <= avail_next;
            if (inc_rx) begin
                rx_cnt <= rx_cnt + CNT_ONE;
            end
            if (inc_ovf) begin
                ovf_cnt <= ovf_cnt + CNT_ONE;
            end
            if (inc_err) begin
                err_cnt <= err_cnt + CNT_ONE;
            end
        end
    end

    // Datapath registers; qualified by their valid bits so no reset is needed.
    always_ff @(posedge clk_i) begin
        out_word  <= out_word_next;
        skid_word <= skid_word_next;
    end

    assign pkt_i_ready    = 1'b1;
    assign pkt_o_data     = out_word.data;
    assign pkt_o_empty    = out_word.empty;
    assign pkt_o_sop      = out_word.sop;
    assign pkt_o_eop      = out_word.eop;
    assign pkt_o_val      = out_val;
    assign pkt_o_err      = 1'b0;
    assign pkt_avail_o    = avail;
    assign rx_pkt_cnt_o   = rx_cnt;
    assign drop_ovf_cnt_o = ovf_cnt;
    assign drop_err_cnt_o = err_cnt;

endmodule
